// File: rtl/demux_rr.sv
// Round-robin demultiplexer: routes a single input word stream onto N_CH
// channels, either burst-locked (MODE 0) or word-by-word (MODE 1).
module demux_rr #(
    parameter int DATA_W    = 8,
    parameter int N_CH      = 4,
    parameter int MODE      = 0,
    parameter int MAX_BURST = 16
) (
    input  logic                     clk2f,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     valid_in,
    input  logic [N_CH-1:0]          ch_en,
    output logic [N_CH*DATA_W-1:0]   data_out,
    output logic [N_CH-1:0]          valid_out,
    output logic [3:0]               active_ch,
    output logic [15:0]              drop_cnt
);

    localparam int          PW     = $clog2(N_CH);
    localparam int unsigned NCH_U  = N_CH;

    typedef enum logic [1:0] {IDLE, TRANS, GAP} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] act;
    logic [7:0]    burst_cnt;

    logic [PW-1:0] base;
    logic [PW-1:0] sel;
    logic          found;
    logic          locked;
    logic          take;
    logic [PW-1:0] route_ch;
    int unsigned   idx;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] c);
        return (32'(c) == NCH_U - 1) ? '0 : c + 1'b1;
    endfunction

    // A full MODE 0 burst restarts the search just past the channel it used.
    always_comb begin
        locked   = (state == TRANS) && (MODE == 0) && (burst_cnt < 8'(MAX_BURST));
        base     = ((state == TRANS) && (MODE == 0)) ? inc(act) : ptr;
        sel      = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned i = 0; i < NCH_U; i++) begin
            idx = (32'(base) + i) % NCH_U;
            if (!found && ch_en[PW'(idx)]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
        take     = valid_in && (locked || found);
        route_ch = locked ? act : sel;
    end

    always_ff @(posedge clk2f or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            act       <= '0;
            burst_cnt <= '0;
            drop_cnt  <= '0;
            valid_out <= '0;
            data_out  <= '0;
        end else begin
            valid_out <= '0;
            data_out  <= '0;
            if (take) begin
                valid_out[route_ch]                      <= 1'b1;
                data_out[32'(route_ch)*DATA_W +: DATA_W] <= data_in;
                act       <= route_ch;
                state     <= TRANS;
                burst_cnt <= locked ? burst_cnt + 8'd1 : 8'd1;
                if (MODE != 0)
                    ptr <= inc(route_ch);
                else if (state == TRANS && !locked)
                    ptr <= inc(act);
            end else if (valid_in) begin
                if (drop_cnt != 16'hFFFF)
                    drop_cnt <= drop_cnt + 16'd1;
                if (state == TRANS) begin
                    state <= GAP;
                    if (MODE == 0)
                        ptr <= inc(act);
                end
            end else if (state == TRANS) begin
                ptr   <= inc(act);
                state <= GAP;
            end
        end
    end

    assign active_ch = 4'(act);

endmodule

// File: tb/tb_demux_rr.sv
// Self-checking bench for demux_rr: table-driven vectors through a scoreboard
// queue plus a hand-written asynchronous-reset sequence.
module tb_demux_rr;

    logic        clk2f = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        valid_in;
    logic [3:0]  ch_en;
    logic [31:0] data_out0, data_out1;
    logic [3:0]  valid_out0, valid_out1;
    logic [3:0]  active_ch0, active_ch1;
    logic [15:0] drop_cnt0, drop_cnt1;

    int tests  = 0;
    int failed = 0;

    always #5 clk2f = ~clk2f;

    demux_rr #(.DATA_W(8), .N_CH(4), .MODE(0), .MAX_BURST(3)) dut0 (
        .clk2f(clk2f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ch_en(ch_en), .data_out(data_out0), .valid_out(valid_out0),
        .active_ch(active_ch0), .drop_cnt(drop_cnt0)
    );

    demux_rr #(.DATA_W(8), .N_CH(4), .MODE(1), .MAX_BURST(3)) dut1 (
        .clk2f(clk2f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ch_en(ch_en), .data_out(data_out1), .valid_out(valid_out1),
        .active_ch(active_ch1), .drop_cnt(drop_cnt1)
    );

    typedef struct {
        bit          rst;
        int          dut;
        logic        v;
        logic [3:0]  en;
        int          ch;
        logic [3:0]  act;
        logic [15:0] drop;
        logic [7:0]  d;
    } vec_t;

    typedef struct {
        int          idx;
        int          dut;
        int          ch;
        logic [7:0]  d;
        logic [3:0]  act;
        logic [15:0] drop;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    task automatic add(input bit rst, input int dut, input logic v, input logic [3:0] en,
                       input int ch, input logic [3:0] act, input logic [15:0] drop);
        vec_t r;
        r.rst = rst; r.dut = dut; r.v = v; r.en = en;
        r.ch = ch; r.act = act; r.drop = drop;
        r.d = 8'(32'h40 + tbl.size());
        tbl.push_back(r);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_exp(input exp_t e);
        logic [31:0] exp_d;
        logic [3:0]  exp_v;
        logic [31:0] got_d;
        logic [3:0]  got_v, got_a;
        logic [15:0] got_c;
        exp_d = '0;
        exp_v = '0;
        if (e.ch >= 0) begin
            exp_v[e.ch]        = 1'b1;
            exp_d[e.ch*8 +: 8] = e.d;
        end
        if (e.dut == 0) begin
            got_d = data_out0; got_v = valid_out0; got_a = active_ch0; got_c = drop_cnt0;
        end else begin
            got_d = data_out1; got_v = valid_out1; got_a = active_ch1; got_c = drop_cnt1;
        end
        check($sformatf("vec%0d valid_out", e.idx), 32'(got_v), 32'(exp_v));
        check($sformatf("vec%0d data_out", e.idx), got_d, exp_d);
        check($sformatf("vec%0d active_ch", e.idx), 32'(got_a), 32'(e.act));
        check($sformatf("vec%0d drop_cnt", e.idx), 32'(got_c), 32'(e.drop));
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        reset    = 1'b1;
        @(posedge clk2f);
        @(negedge clk2f);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        ch_en    = '0;
        #12;
        check("reset valid_out0", 32'(valid_out0), 32'h0);
        check("reset data_out0", data_out0, 32'h0);
        check("reset active_ch0", 32'(active_ch0), 32'h0);
        check("reset drop_cnt0", 32'(drop_cnt0), 32'h0);
        check("reset valid_out1", 32'(valid_out1), 32'h0);
        @(negedge clk2f);
        reset = 1'b0;

        // three bursts A0,A1 / B0 / C0..C2 with all channels enabled
        add(0,0,1,4'hF, 0,0,0); add(0,0,1,4'hF, 0,0,0); add(0,0,0,4'hF,-1,0,0);
        add(0,0,1,4'hF, 1,1,0); add(0,0,0,4'hF,-1,1,0);
        add(0,0,1,4'hF, 2,2,0); add(0,0,1,4'hF, 2,2,0); add(0,0,1,4'hF, 2,2,0);
        add(0,0,0,4'hF,-1,2,0);
        // 7-word continuous burst with MAX_BURST=3
        add(1,0,1,4'hF, 0,0,0); add(0,0,1,4'hF, 0,0,0); add(0,0,1,4'hF, 0,0,0);
        add(0,0,1,4'hF, 1,1,0); add(0,0,1,4'hF, 1,1,0); add(0,0,1,4'hF, 1,1,0);
        add(0,0,1,4'hF, 2,2,0); add(0,0,0,4'hF,-1,2,0);
        // sparse enable mask, then an all-disabled drop
        add(1,0,1,4'hA, 1,1,0); add(0,0,0,4'hA,-1,1,0);
        add(0,0,1,4'hA, 3,3,0); add(0,0,0,4'hA,-1,3,0);
        add(0,0,1,4'h0,-1,3,1); add(0,0,0,4'h0,-1,3,1);
        add(0,0,1,4'hF, 0,0,1); add(0,0,0,4'hF,-1,0,1);
        // enable removed from active channel mid-burst
        add(1,0,1,4'h3, 0,0,0); add(0,0,0,4'h3,-1,0,0);
        add(0,0,1,4'h3, 1,1,0); add(0,0,1,4'h1, 1,1,0); add(0,0,1,4'h1, 1,1,0);
        add(0,0,0,4'h1,-1,1,0); add(0,0,1,4'h1, 0,0,0); add(0,0,0,4'h1,-1,0,0);
        // burst limit reached with nothing enabled
        add(1,0,1,4'h3, 0,0,0); add(0,0,1,4'h3, 0,0,0); add(0,0,1,4'h3, 0,0,0);
        add(0,0,1,4'h0,-1,0,1); add(0,0,1,4'hF, 1,1,1); add(0,0,0,4'hF,-1,1,1);
        // word round-robin
        add(1,1,1,4'hF, 0,0,0); add(0,1,1,4'hF, 1,1,0); add(0,1,1,4'hF, 2,2,0);
        add(0,1,1,4'hF, 3,3,0); add(0,1,1,4'hF, 0,0,0); add(0,1,1,4'hF, 1,1,0);
        add(0,1,0,4'hF,-1,1,0); add(0,1,1,4'h5, 2,2,0); add(0,1,1,4'h5, 0,0,0);
        add(0,1,1,4'h0,-1,0,1); add(0,1,0,4'h0,-1,0,1);

        foreach (tbl[i]) begin
            @(negedge clk2f);
            if (sb.size() > 0) check_exp(sb.pop_front());
            if (tbl[i].rst) do_reset();
            valid_in = tbl[i].v;
            data_in  = tbl[i].d;
            ch_en    = tbl[i].en;
            e.idx = i; e.dut = tbl[i].dut; e.ch = tbl[i].ch;
            e.d = tbl[i].d; e.act = tbl[i].act; e.drop = tbl[i].drop;
            sb.push_back(e);
        end
        @(negedge clk2f);
        valid_in = 1'b0;
        while (sb.size() > 0) check_exp(sb.pop_front());

        // asynchronous reset on the second word of a burst to ch2
        do_reset();
        ch_en    = 4'b0100;
        valid_in = 1'b1;
        data_in  = 8'hA5;
        @(negedge clk2f);
        check("rst seq word0 valid", 32'(valid_out0), 32'h4);
        data_in = 8'hA6;
        @(posedge clk2f);
        #2;
        check("rst seq word1 valid", 32'(valid_out0), 32'h4);
        check("rst seq word1 data", data_out0, 32'h00A6_0000);
        reset = 1'b1;
        #1;
        check("rst seq async valid", 32'(valid_out0), 32'h0);
        check("rst seq async data", data_out0, 32'h0);
        check("rst seq async active", 32'(active_ch0), 32'h0);
        @(negedge clk2f);
        reset    = 1'b0;
        ch_en    = 4'hF;
        valid_in = 1'b1;
        data_in  = 8'h5A;
        @(negedge clk2f);
        valid_in = 1'b0;
        check("rst seq after valid", 32'(valid_out0), 32'h1);
        check("rst seq after data", data_out0, 32'h0000_005A);
        check("rst seq after drop", 32'(drop_cnt0), 32'h0);
        @(negedge clk2f);
        check("rst seq idle valid", 32'(valid_out0), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
